// File: rtl/display_driver.sv
// display_driver: scans an RGB LED matrix, S+1 PWM shift passes per row, S = 2^cyclewidth.
// Pixel memory reads take 1 clk, so rgb/oclk/oe/lat trail the row/column address by 2 clks.
// Define DISPLAY_DRIVER_DEBUG_EN to add output 'slot' carrying the current pass index.
module display_driver #(
  parameter int segments   = 1,
  parameter int rows       = 8,
  parameter int columns    = 32,
  parameter int bitwidth   = 8,
  parameter int cyclewidth = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [$clog2(rows)-1:0]         row,
  output logic [$clog2(columns)-1:0]      column,
  input  logic [3*bitwidth*segments-1:0]  pixel,
  output logic [3*segments-1:0]           rgb,
  output logic                            oe,
  output logic                            lat,
  output logic                            oclk,
  output logic                            frame_complete
`ifdef DISPLAY_DRIVER_DEBUG_EN
  ,
  output logic [cyclewidth:0]             slot
`endif
);

  localparam int RW = $clog2(rows);
  localparam int CW = $clog2(columns);
  // Step counter walks 2*columns half-cycles; its LSB is the oclk phase.
  localparam int NW = CW + 1;

  localparam logic [NW-1:0]         LAST_STEP = NW'(2 * columns - 1);
  localparam logic [RW-1:0]         LAST_ROW  = RW'(rows - 1);
  localparam logic [cyclewidth:0]   LAST_PASS = {1'b1, {cyclewidth{1'b0}}};

  typedef enum logic [1:0] {
    ST_SHIFT,  // issuing column addresses for one pass
    ST_BLANK,  // panel dark, oclk idle
    ST_LATCH,  // latch strobe while dark
    ST_END     // end of row: dark, then advance row
  } state_t;

  state_t                r_state;
  logic [NW-1:0]         r_cnt;
  logic [cyclewidth:0]   r_pass;
  logic [RW-1:0]         r_row;
  logic                  r_fc;

  // Pipeline stage 1 (pixel data arriving) and stage 2 (panel outputs)
  logic                  r_v1, r_h1, r_oe1, r_lat1;
  logic                  r_oclk, r_oe, r_lat;
  logic [3*segments-1:0] r_rgb;

  logic                  w_v0, w_oe0, w_lat0;
  logic [3*segments-1:0] w_rgb;

  // A channel is lit when its top cyclewidth bits are non-zero and at least the slot.
  // Comparing the full channel against slot<<shift is equivalent and uses every bit.
  function automatic logic chan_on(input logic [bitwidth-1:0] ch,
                                   input logic [cyclewidth-1:0] p);
    logic [bitwidth-1:0] thr;
    thr = bitwidth'(p) << (bitwidth - cyclewidth);
    return (ch >= thr) && ((ch >> (bitwidth - cyclewidth)) != '0);
  endfunction

  assign w_v0  = (r_state == ST_SHIFT);
  assign w_oe0 = w_v0 && (r_pass != '0);
  assign w_lat0 = (r_state == ST_LATCH);

  // Threshold every channel of every segment against the current slot (pass mod S)
  always_comb begin
    w_rgb = '0;
    for (int s = 0; s < segments; s++) begin
      for (int c = 0; c < 3; c++) begin
        w_rgb[3*s+c] = chan_on(pixel[bitwidth*(3*s+c) +: bitwidth], r_pass[cyclewidth-1:0]);
      end
    end
  end

  // Scan sequencer: passes, gaps, latch, row advance and frame-complete pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SHIFT;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_row   <= '0;
      r_fc    <= 1'b0;
    end else begin
      r_fc <= 1'b0;
      case (r_state)
        ST_SHIFT: begin
          if (r_cnt == LAST_STEP) begin
            r_cnt   <= '0;
            r_state <= (r_pass == LAST_PASS) ? ST_END : ST_BLANK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BLANK: r_state <= ST_LATCH;
        ST_LATCH: begin
          // Pass advances only once the previous pass's data has left the pipeline
          r_pass  <= r_pass + 1'b1;
          r_state <= ST_SHIFT;
        end
        ST_END: begin
          r_cnt <= r_cnt + 1'b1;
          // Timed so the pulse lands on the first dark output cycle, before the row moves
          if (r_cnt == NW'(1)) begin
            r_fc <= (r_row == LAST_ROW);
          end
          if (r_cnt == NW'(2)) begin
            r_cnt   <= '0;
            r_pass  <= '0;
            r_row   <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        default: r_state <= ST_SHIFT;
      endcase
    end
  end

  // Delay the control stream two clks so it lines up with the memory data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_h1   <= 1'b0;
      r_oe1  <= 1'b0;
      r_lat1 <= 1'b0;
      r_oclk <= 1'b0;
      r_oe   <= 1'b0;
      r_lat  <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_v1   <= w_v0;
      r_h1   <= r_cnt[0];
      r_oe1  <= w_oe0;
      r_lat1 <= w_lat0;
      r_oclk <= r_v1 & r_h1;
      r_oe   <= r_oe1;
      r_lat  <= r_lat1;
      r_rgb  <= r_v1 ? w_rgb : '0;
    end
  end

  assign row            = r_row;
  assign column         = r_cnt[NW-1:1];
  assign rgb            = r_rgb;
  assign oe             = r_oe;
  assign lat            = r_lat;
  assign oclk           = r_oclk;
  assign frame_complete = r_fc;
`ifdef DISPLAY_DRIVER_DEBUG_EN
  assign slot           = r_pass;
`endif

endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: small panel (2 segments, 4 rows, 8 columns, 16 slots) for a short run.
module tb_display_driver;

  localparam int SEG  = 2;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int BW   = 8;
  localparam int CYW  = 4;
  localparam int S    = 1 << CYW;
  localparam int PW   = 3 * BW * SEG;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      row;
  logic [2:0]      column;
  logic [PW-1:0]   pixel;
  logic [3*SEG-1:0] rgb;
  logic            oe, lat, oclk, frame_complete;
`ifdef DISPLAY_DRIVER_DEBUG_EN
  logic [CYW:0]    slot;
`endif

  display_driver #(
    .segments(SEG), .rows(ROWS), .columns(COLS), .bitwidth(BW), .cyclewidth(CYW)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .pixel(pixel), .rgb(rgb),
    .oe(oe), .lat(lat), .oclk(oclk), .frame_complete(frame_complete)
`ifdef DISPLAY_DRIVER_DEBUG_EN
    , .slot(slot)
`endif
  );

  always #5 clk = ~clk;

  // Pixel memory with one clock of read latency
  logic [PW-1:0] mem [ROWS][COLS];
  always @(posedge clk) pixel <= mem[row][column];

  int vectors = 0;
  int miscompares = 0;

  // Reference scan position, tracked from observed panel events
  int m_row, m_pass, m_cols, fc_count;
  bit m_fc_seen, p_oclk, p_lat, p_fc;
  logic [3*SEG-1:0] p_rgb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected shift data: channel on iff top CYW bits nonzero and >= pass mod S
  function automatic logic [3*SEG-1:0] model_rgb(int r, int c, int p);
    logic [PW-1:0] w;
    logic [3*SEG-1:0] o;
    int v;
    w = mem[r][c];
    o = '0;
    for (int k = 0; k < 3 * SEG; k++) begin
      v = int'(w[k*BW +: BW]) / (1 << (BW - CYW));
      o[k] = (v != 0) && (v >= (p % S));
    end
    return o;
  endfunction

  task automatic mon_clear();
    m_row = 0; m_pass = 0; m_cols = 0; m_fc_seen = 0;
    p_oclk = 0; p_lat = 0; p_fc = 0; p_rgb = '0;
  endtask

  task automatic fill_mem();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = PW'({$urandom(), $urandom()});
    mem[0][0][23:0] = {8'h80, 8'hFF, 8'h00};
    mem[0][1][23:0] = {8'h0F, 8'h10, 8'hF0};
    mem[1][0][47:24] = 24'h000000;
    mem[2][COLS-1] = {PW{1'b1}};
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_row"}, row, 0);
    chk({pfx, "_column"}, column, 0);
    chk({pfx, "_rgb"}, rgb, 0);
    chk({pfx, "_oe"}, oe, 0);
    chk({pfx, "_lat"}, lat, 0);
    chk({pfx, "_oclk"}, oclk, 0);
    chk({pfx, "_fc"}, frame_complete, 0);
  endtask

  // One clock: sample on the falling edge and check panel protocol against the model
  task automatic tick();
    @(negedge clk);
    chk("lat_and_oclk", lat & oclk, 0);
    chk("lat_and_oe", lat & oe, 0);
    if (row != 2'(m_row)) begin
      chk("row_next", row, (m_row + 1) % ROWS);
      chk("row_passes", m_pass, S);
      chk("row_last_cols", m_cols, COLS);
      chk("row_oe", oe, 0);
      chk("fc_before_row_change", m_fc_seen, row == 0);
      m_fc_seen = 0;
      m_row = int'(row);
      m_pass = 0;
      m_cols = 0;
    end
    if (frame_complete) begin
      chk("fc_row", row, ROWS - 1);
      chk("fc_passes", m_pass, S);
      chk("fc_cols", m_cols, COLS);
      chk("fc_oe", oe, 0);
      chk("fc_lat", lat, 0);
      chk("fc_oclk", oclk, 0);
      chk("fc_width", p_fc, 0);
      m_fc_seen = 1;
      fc_count++;
    end
    if (oclk) begin
      chk("oclk_shape", p_oclk, 0);
      chk("cols_per_pass", m_cols < COLS, 1);
      chk("rgb_data", rgb, model_rgb(m_row, m_cols % COLS, m_pass));
      chk("rgb_stable", rgb, p_rgb);
      chk("oe_shift", oe, m_pass != 0);
      m_cols++;
    end
    if (lat) begin
      chk("lat_width", p_lat, 0);
      chk("lat_cols", m_cols, COLS);
      chk("lat_oe", oe, 0);
      m_pass++;
      m_cols = 0;
      chk("lat_per_row", m_pass <= S, 1);
    end
    if (!lat && p_lat) chk("oe_after_lat", oe, 1);
    if (m_pass == 0) chk("oe_pass0", oe, 0);
    p_oclk = oclk; p_lat = lat; p_fc = frame_complete; p_rgb = rgb;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    fill_mem();
    fc_count = 0;
    mon_clear();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    n = 0;
    while (fc_count < 1 && n < 3000) begin tick(); n++; end
    chk("frame1_complete", fc_count, 1);

    // Run into the middle of a pass in row 3, then reset asynchronously
    n = 0;
    while (!(row == 2'd3 && m_pass == 2 && m_cols == 3) && n < 3000) begin tick(); n++; end
    chk("reach_row3", row, 3);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    fill_mem();
    repeat (2) @(negedge clk);
    chk_all_zero("midrst_hold");
    rst = 1'b0;
    mon_clear();
    tick();
    chk("post_rst_row", row, 0);
    chk("post_rst_oe", oe, 0);

    n = 0;
    while (fc_count < 2 && n < 3000) begin tick(); n++; end
    chk("frame2_complete", fc_count, 2);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_driver.md
DISPLAY_DRIVER -- requirements
Module: display_driver

Interface
REQ-001 Param segments, default 1: count of panel segments driven in parallel.
REQ-002 Param rows, default 8: rows per segment.
REQ-003 Param columns, default 32: columns per row.
REQ-004 Param bitwidth, default 8: bits per colour channel.
REQ-005 Param cyclewidth, default 8: PWM slot counter width; S = 2^cyclewidth slots.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 row  out  clog2(rows)  pixel-memory row address and displayed panel row.
REQ-009 column  out  clog2(columns)  pixel-memory column address.
REQ-010 pixel  in  3*bitwidth*segments  memory data, valid one clk after its row/column; per segment s: R=[3bw*s+3bw-1 -: bw], G next, B lowest.
REQ-011 rgb  out  3*segments  shift data; rgb[3s+2]=R, [3s+1]=G, [3s]=B.
REQ-012 oe  out  1  display enable, active-high (1 = LEDs lit).
REQ-013 lat  out  1  latch strobe, active-high.
REQ-014 oclk  out  1  shift clock; panel samples rgb on rising edge.
REQ-015 frame_complete  out  1  one-clk pulse when a full frame has been scanned.

Function
REQ-016 Per row, SHALL run S+1 shift passes p=0..S; each pass emits exactly `columns` oclk pulses, column 0 first.
REQ-017 Each oclk pulse SHALL be 1 clk low then 1 clk high; rgb SHALL be stable from the low phase through the falling edge.
REQ-018 Channel bit for pass p SHALL be 1 iff value != 0 and value >= (p mod S), value = channel's top cyclewidth bits.
REQ-019 Address SHALL lead rgb by the 1-clk memory latency plus one register stage; column output is don't-care outside shifting.
REQ-020 oe SHALL be 0 during the whole of pass 0 and 1 during shifting of passes 1..S.
REQ-021 After passes 0..S-1: oclk low, oe 0 for 1 clk, lat 1 for 1 clk with oe 0, lat 0 then oe 1 before next pass's first oclk rise.
REQ-022 After pass S: no latch; oe SHALL fall to 0, then row advances (rows-1 wraps to 0).
REQ-023 row SHALL stay constant across all S+1 passes of that row, including pass S.
REQ-024 After pass S of row rows-1, frame_complete SHALL pulse 1 clk with lat, oe, oclk all 0, then scanning restarts at row 0 pass 0.
REQ-025 lat and oclk SHALL never be high simultaneously; lat never high while oe is 1.
REQ-026 frame_complete SHALL be 0 at all other times.

Reset
REQ-027 While rst=1: row 0, column 0, rgb 0, oe 0, lat 0, oclk 0, frame_complete 0; counters cleared.
REQ-028 Reset mid-pass SHALL abort immediately; after release, scanning restarts at row 0 pass 0 on the first clk edge.

Configuration
REQ-029 Macro DISPLAY_DRIVER_DEBUG_EN: when defined, adds output slot (cyclewidth+1 bits) = current pass index p; when undefined the port and its logic SHALL be absent; scan behaviour identical either way.

Verification
REQ-030 segments=1, rows=8, columns=32, pixel (0,0)=FF0000, rest 0: for rows 0 and 1, each of 257 passes has 32 oclk rises; rgb=100 at row 0 col 0, else 000.
REQ-031 Same setup: lat pulses 256 times per row with oe=0 and oclk=0; oe=1 after each lat fall; oe=0 throughout pass 0.
REQ-032 Same setup: on pass 256 no lat; oe falls with oclk=0; row then increments; row constant within each row's passes.
REQ-033 Full frame: after row 7 pass 256, frame_complete pulses one clk with lat=oe=oclk=0, then row=0 pass 0.
REQ-034 Pixel value 0x80 red: R=1 on passes with p mod 256 in 1..128 and on pass 0/256, R=0 on passes 129..255.
REQ-035 Assert rst mid-pass in row 3: all outputs 0 within the reset; after release, row=0, oe=0, first pass is pass 0.
